// File: rtl/noc_pkg.sv
// Shared definitions for the PE/NoC endpoint: flit field helpers, counter width
// and the depth-to-pointer-width helper used by the FIFOs.
package noc_pkg;

  localparam int COUNT_W = 16;

  // Flits are handled zero-extended to 64 bits so one helper serves any widths.
  function automatic logic [63:0] dest_of(input logic [63:0] flit, input int data_w);
    return flit >> data_w;
  endfunction

  function automatic logic [63:0] payload_of(input logic [63:0] flit, input int data_w);
    return flit & ((64'd1 << data_w) - 64'd1);
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; full/empty are registered so the
// handshake readies depend only on stored occupancy.
module noc_sync_fifo
  import noc_pkg::*;
#(
  parameter int Width = 32,
  parameter int Depth = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic [Width-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = clog2(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             r_full;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;
  logic [AW:0]      w_count_nxt;

  assign w_push = i_push & ~r_full;
  assign w_pop  = i_pop & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + 1'b1;
    else if (!w_push && w_pop) w_count_nxt = r_count - 1'b1;
  end

  // Pointers wrap naturally since Depth is a power of two; the extra count bit
  // keeps full and empty distinct when the pointers coincide.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == (AW+1)'(Depth));
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  assign o_data  = r_mem[r_rptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/pe_noc_interface.sv
// PE-side leaf endpoint of the binary-tree NoC: buffers core requests into flits
// toward the tree and filters/strips incoming flits addressed to this PE.
module pe_noc_interface
  import noc_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 2,
  parameter int MyAddr    = 0,
  parameter int TxDepth   = 2,
  parameter int RxDepth   = 4
) (
  input  logic                           i_sclk,
  input  logic                           i_reset,
  input  logic [DataWidth-1:0]           i_core_data,
  input  logic [AddrWidth-1:0]           i_core_dest,
  input  logic                           i_core_valid,
  output logic                           o_core_ready,
  output logic [DataWidth+AddrWidth-1:0] o_noc_data,
  output logic                           o_noc_valid,
  input  logic                           i_noc_ready,
  input  logic [DataWidth+AddrWidth-1:0] i_noc_data,
  input  logic                           i_noc_valid,
  output logic                           o_noc_ready,
  output logic [DataWidth-1:0]           o_core_data,
  output logic                           o_core_valid,
  input  logic                           i_core_ready,
  output logic [COUNT_W-1:0]             o_tx_count,
  output logic [COUNT_W-1:0]             o_rx_count,
  output logic                           o_misroute
);

  localparam int FlitW = DataWidth + AddrWidth;

  logic [FlitW-1:0]     w_tx_head;
  logic                 w_tx_full;
  logic                 w_tx_empty;
  logic                 w_tx_fire;
  logic [DataWidth-1:0] w_rx_head;
  logic                 w_rx_full;
  logic                 w_rx_empty;
  logic                 w_noc_fire;
  logic                 w_dest_match;
  logic                 w_rx_push;
  logic [COUNT_W-1:0]   r_tx_count;
  logic [COUNT_W-1:0]   r_rx_count;
  logic                 r_misroute;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  noc_sync_fifo #(.Width(FlitW), .Depth(TxDepth)) u_tx_fifo (
    .i_clk   (i_sclk),
    .i_reset (i_reset),
    .i_push  (i_core_valid),
    .i_data  ({i_core_dest, i_core_data}),
    .i_pop   (i_noc_ready),
    .o_data  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  // Valids are masked in the reset cycle so nothing stale is offered downstream.
  assign o_core_ready = ~w_tx_full;
  assign o_noc_valid  = ~w_tx_empty & ~i_reset;
  assign o_noc_data   = w_tx_head;
  assign w_tx_fire    = o_noc_valid & i_noc_ready;

  // Misrouted flits are still accepted (and dropped) only when not full.
  assign w_noc_fire   = i_noc_valid & ~w_rx_full;
  assign w_dest_match = (dest_of(64'(i_noc_data), DataWidth) == 64'(MyAddr));
  assign w_rx_push    = w_noc_fire & w_dest_match;

  noc_sync_fifo #(.Width(DataWidth), .Depth(RxDepth)) u_rx_fifo (
    .i_clk   (i_sclk),
    .i_reset (i_reset),
    .i_push  (w_rx_push),
    .i_data  (i_noc_data[DataWidth-1:0]),
    .i_pop   (i_core_ready),
    .o_data  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  assign o_noc_ready  = ~w_rx_full;
  assign o_core_valid = ~w_rx_empty & ~i_reset;
  assign o_core_data  = w_rx_head;

  always_ff @(posedge i_sclk) begin
    if (i_reset) begin
      r_tx_count <= '0;
      r_rx_count <= '0;
      r_misroute <= 1'b0;
    end else begin
      if (w_tx_fire) r_tx_count <= sat_inc(r_tx_count);
      if (w_rx_push) r_rx_count <= sat_inc(r_rx_count);
      if (w_noc_fire && !w_dest_match) r_misroute <= 1'b1;
    end
  end

  assign o_tx_count = r_tx_count;
  assign o_rx_count = r_rx_count;
  assign o_misroute = r_misroute;

endmodule

// File: tb/tb_pe_noc_interface.sv
// Randomised and directed bench for pe_noc_interface against a queue-based
// reference model of the two buffered paths.
module tb_pe_noc_interface;

  localparam int DW  = 32;
  localparam int AW  = 2;
  localparam int MY  = 1;
  localparam int TXD = 2;
  localparam int RXD = 4;

  logic           clk;
  logic           i_reset;
  logic [DW-1:0]  i_core_data;
  logic [AW-1:0]  i_core_dest;
  logic           i_core_valid;
  logic           o_core_ready;
  logic [DW+AW-1:0] o_noc_data;
  logic           o_noc_valid;
  logic           i_noc_ready;
  logic [DW+AW-1:0] i_noc_data;
  logic           i_noc_valid;
  logic           o_noc_ready;
  logic [DW-1:0]  o_core_data;
  logic           o_core_valid;
  logic           i_core_ready;
  logic [15:0]    o_tx_count;
  logic [15:0]    o_rx_count;
  logic           o_misroute;

  pe_noc_interface #(
    .DataWidth(DW), .AddrWidth(AW), .MyAddr(MY), .TxDepth(TXD), .RxDepth(RXD)
  ) dut (
    .i_sclk       (clk),
    .i_reset      (i_reset),
    .i_core_data  (i_core_data),
    .i_core_dest  (i_core_dest),
    .i_core_valid (i_core_valid),
    .o_core_ready (o_core_ready),
    .o_noc_data   (o_noc_data),
    .o_noc_valid  (o_noc_valid),
    .i_noc_ready  (i_noc_ready),
    .i_noc_data   (i_noc_data),
    .i_noc_valid  (i_noc_valid),
    .o_noc_ready  (o_noc_ready),
    .o_core_data  (o_core_data),
    .o_core_valid (o_core_valid),
    .i_core_ready (i_core_ready),
    .o_tx_count   (o_tx_count),
    .o_rx_count   (o_rx_count),
    .o_misroute   (o_misroute)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  // Reference model: plain queues and counters
  logic [DW+AW-1:0] tx_q[$];
  logic [DW-1:0]    rx_q[$];
  int m_tx_cnt = 0;
  int m_rx_cnt = 0;
  bit m_mis = 1'b0;
  bit tpop, tpush, rpop, rhs;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (i_reset) begin
      tx_q.delete();
      rx_q.delete();
      m_tx_cnt = 0;
      m_rx_cnt = 0;
      m_mis = 1'b0;
    end else begin
      tpop  = (tx_q.size() > 0) && i_noc_ready;
      tpush = i_core_valid && (tx_q.size() < TXD);
      rpop  = (rx_q.size() > 0) && i_core_ready;
      rhs   = i_noc_valid && (rx_q.size() < RXD);
      if (tpop) begin
        void'(tx_q.pop_front());
        if (m_tx_cnt < 65535) m_tx_cnt++;
      end
      if (tpush) tx_q.push_back({i_core_dest, i_core_data});
      if (rpop) void'(rx_q.pop_front());
      if (rhs) begin
        if (int'(i_noc_data[DW+AW-1:DW]) == MY) begin
          rx_q.push_back(i_noc_data[DW-1:0]);
          if (m_rx_cnt < 65535) m_rx_cnt++;
        end else begin
          m_mis = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("noc_valid", 64'(o_noc_valid), 64'(!i_reset && tx_q.size() > 0));
      if (!i_reset && tx_q.size() > 0) chk("noc_data", 64'(o_noc_data), 64'(tx_q[0]));
      chk("core_ready", 64'(o_core_ready), 64'(tx_q.size() < TXD));
      chk("noc_ready", 64'(o_noc_ready), 64'(rx_q.size() < RXD));
      chk("core_valid", 64'(o_core_valid), 64'(!i_reset && rx_q.size() > 0));
      if (!i_reset && rx_q.size() > 0) chk("core_data", 64'(o_core_data), 64'(rx_q[0]));
      chk("tx_count", 64'(o_tx_count), 64'(m_tx_cnt));
      chk("rx_count", 64'(o_rx_count), 64'(m_rx_cnt));
      chk("misroute", 64'(o_misroute), 64'(m_mis));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_core_valid = 1'b0;
    i_noc_valid  = 1'b0;
    i_core_data  = '0;
    i_core_dest  = '0;
    i_noc_data   = '0;
    i_noc_ready  = 1'b1;
    i_core_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_reset = 1'b1;
    step();
    step();
    i_reset = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1;
    idle_inputs();
    do_reset();
    check_en = 1'b1;

    // Reset state
    step();
    @(negedge clk);
    chk("rst_noc_valid", 64'(o_noc_valid), 64'd0);
    chk("rst_core_valid", 64'(o_core_valid), 64'd0);
    chk("rst_core_ready", 64'(o_core_ready), 64'd1);
    chk("rst_noc_ready", 64'(o_noc_ready), 64'd1);
    chk("rst_counts", 64'({o_tx_count, o_rx_count}), 64'd0);
    chk("rst_misroute", 64'(o_misroute), 64'd0);

    // Single send with one-cycle latency
    step();
    i_core_valid = 1'b1; i_core_dest = 2'd2; i_core_data = 32'hDEADBEEF; i_noc_ready = 1'b1;
    step();
    i_core_valid = 1'b0;
    @(negedge clk);
    chk("tx1_valid", 64'(o_noc_valid), 64'd1);
    chk("tx1_data", 64'(o_noc_data), 64'h2_DEADBEEF);
    step();
    @(negedge clk);
    chk("tx1_after_valid", 64'(o_noc_valid), 64'd0);
    chk("tx1_count", 64'(o_tx_count), 64'd1);

    // TX full then drain in order
    do_reset();
    i_noc_ready = 1'b0;
    i_core_valid = 1'b1; i_core_dest = 2'd0; i_core_data = 32'h11111111;
    step();
    i_core_dest = 2'd1; i_core_data = 32'h22222222;
    step();
    i_core_dest = 2'd3; i_core_data = 32'h33333333;
    @(negedge clk);
    chk("txfull_ready", 64'(o_core_ready), 64'd0);
    chk("txfull_head", 64'(o_noc_data), 64'h0_11111111);
    step();
    i_noc_ready = 1'b1;
    step();
    @(negedge clk);
    chk("txfull_ready_back", 64'(o_core_ready), 64'd1);
    chk("txfull_head2", 64'(o_noc_data), 64'h1_22222222);
    step();
    i_core_valid = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("txfull_count", 64'(o_tx_count), 64'd3);
    chk("txfull_empty", 64'(o_noc_valid), 64'd0);

    // RX delivery and misroute
    do_reset();
    i_core_ready = 1'b0;
    i_noc_valid = 1'b1; i_noc_data = {2'd1, 32'd5};
    step();
    i_noc_data = {2'd1, 32'd6};
    step();
    i_noc_valid = 1'b0;
    @(negedge clk);
    chk("rx_first", 64'(o_core_data), 64'd5);
    chk("rx_count2", 64'(o_rx_count), 64'd2);
    step();
    i_core_ready = 1'b1;
    step();
    i_core_ready = 1'b0;
    @(negedge clk);
    chk("rx_second", 64'(o_core_data), 64'd6);
    step();
    i_noc_valid = 1'b1; i_noc_data = {2'd3, 32'd7};
    step();
    i_noc_valid = 1'b0;
    @(negedge clk);
    chk("mis_flag", 64'(o_misroute), 64'd1);
    chk("mis_rxcount", 64'(o_rx_count), 64'd2);
    chk("mis_data", 64'(o_core_data), 64'd6);

    // RX full back-pressure
    do_reset();
    i_core_ready = 1'b0;
    i_noc_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_noc_data = {2'd1, 32'(100 + k)};
      step();
    end
    i_noc_data = {2'd1, 32'd104};
    @(negedge clk);
    chk("rxfull_ready", 64'(o_noc_ready), 64'd0);
    step();
    i_core_ready = 1'b1;
    step();
    i_core_ready = 1'b0;
    @(negedge clk);
    chk("rxfull_ready_back", 64'(o_noc_ready), 64'd1);
    step();
    i_noc_valid = 1'b0;
    @(negedge clk);
    chk("rxfull_count", 64'(o_rx_count), 64'd5);
    chk("rxfull_head", 64'(o_core_data), 64'd101);

    // Reset with traffic buffered
    do_reset();
    i_noc_ready = 1'b0; i_core_ready = 1'b0;
    i_core_valid = 1'b1; i_noc_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_core_data = 32'(200 + k); i_core_dest = 2'(k);
      i_noc_data = {(k == 2) ? 2'd2 : 2'd1, 32'(300 + k)};
      step();
    end
    i_core_valid = 1'b0; i_noc_valid = 1'b0;
    i_reset = 1'b1;
    @(negedge clk);
    chk("rstmid_noc_valid", 64'(o_noc_valid), 64'd0);
    chk("rstmid_core_valid", 64'(o_core_valid), 64'd0);
    step();
    i_reset = 1'b0;
    i_noc_ready = 1'b1; i_core_ready = 1'b1;
    @(negedge clk);
    chk("rstmid_counts", 64'({o_tx_count, o_rx_count}), 64'd0);
    chk("rstmid_mis", 64'(o_misroute), 64'd0);
    chk("rstmid_valids", 64'({o_noc_valid, o_core_valid}), 64'd0);
    repeat (4) step();

    // Randomised traffic with occasional resets
    for (int c = 0; c < 4000; c++) begin
      i_reset      = ($urandom_range(0, 299) == 0);
      i_core_valid = $urandom_range(0, 1);
      i_core_dest  = 2'($urandom_range(0, 3));
      i_core_data  = $urandom;
      i_noc_ready  = ($urandom_range(0, 3) != 0);
      i_noc_valid  = $urandom_range(0, 1);
      i_noc_data   = {2'($urandom_range(0, 3)), 32'($urandom)};
      i_core_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    // Counter saturation
    do_reset();
    i_core_valid = 1'b1; i_core_dest = 2'd3; i_core_data = 32'hA5A5A5A5;
    i_noc_valid = 1'b1; i_noc_data = {2'd1, 32'h5A5A5A5A};
    repeat (65540) step();
    @(negedge clk);
    chk("sat_tx", 64'(o_tx_count), 64'hFFFF);
    chk("sat_rx", 64'(o_rx_count), 64'hFFFF);
    idle_inputs();
    repeat (4) step();

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
